// File: rtl/buzzer_pkg.sv
// buzzer_pkg: shared types and constants for the buzzer burst sequencer.
//   state_t         FSM states (IDLE/BEEP/GAP)
//   HALF_PERIOD_*   tone half-periods in clk cycles at 100 MHz (~262/330/392/523 Hz)
//   TEST_*          small-size overrides used for fast simulation builds
//   half_period()   tone index -> half-period lookup (full or test-size table)
package buzzer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BEEP = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam int unsigned HALF_PERIOD_0 = 190_840;
   localparam int unsigned HALF_PERIOD_1 = 151_515;
   localparam int unsigned HALF_PERIOD_2 = 127_551;
   localparam int unsigned HALF_PERIOD_3 = 95_602;

   localparam int unsigned TEST_HALF_PERIOD_0 = 2;
   localparam int unsigned TEST_HALF_PERIOD_1 = 3;
   localparam int unsigned TEST_HALF_PERIOD_2 = 4;
   localparam int unsigned TEST_HALF_PERIOD_3 = 5;
   localparam int unsigned TEST_BEEP_CYCLES   = 20;
   localparam int unsigned TEST_GAP_CYCLES    = 10;

   // Half-period lookup; test_size selects the shortened table.
   function automatic int unsigned half_period(input logic [1:0] sel, input bit test_size);
      int unsigned hp;
      hp = HALF_PERIOD_0;
      case (sel)
         2'd0: hp = test_size ? TEST_HALF_PERIOD_0 : HALF_PERIOD_0;
         2'd1: hp = test_size ? TEST_HALF_PERIOD_1 : HALF_PERIOD_1;
         2'd2: hp = test_size ? TEST_HALF_PERIOD_2 : HALF_PERIOD_2;
         default: hp = test_size ? TEST_HALF_PERIOD_3 : HALF_PERIOD_3;
      endcase
      return hp;
   endfunction

endpackage

// File: rtl/buzzer_seq_tone_div.sv
// tone_div: square-wave generator with programmable half-period.
//   clk, rst_n    clock, async active-low reset
//   en            run the divider; low forces wave 0 and count 0
//   clr           restart: wave forced 1, count 0 (has priority over en)
//   half_period   toggle interval in clk cycles (>=1)
//   wave          registered square-wave output
module tone_div #(
   parameter int unsigned HP_W = 20
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic            clr,
   input  logic [HP_W-1:0] half_period,
   output logic            wave
);

   logic [HP_W-1:0] cnt;

   // Half counter wraps at half_period-1, toggling the output each wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         wave <= 1'b0;
      end else if (clr) begin
         cnt  <= '0;
         wave <= 1'b1;
      end else if (!en) begin
         cnt  <= '0;
         wave <= 1'b0;
      end else if (cnt == half_period - HP_W'(1)) begin
         cnt  <= '0;
         wave <= ~wave;
      end else begin
         cnt  <= cnt + HP_W'(1);
      end
   end

endmodule

// File: rtl/buzzer_seq.sv
// buzzer_seq: plays a burst of 1-8 square-wave beeps on a one-cycle start.
//   clk, rst_n   clock, async active-low reset
//   start        request pulse (ignored while busy unless retriggering enabled)
//   tone         pitch index, latched at accept
//   num          beep count minus one, latched at accept
//   buzz         square-wave drive to the buzzer (0 whenever not beeping)
//   busy         high while a burst is in progress
//   done         one-cycle pulse when a burst completes normally
// Build option: BUZZER_RETRIGGER_EN - start while busy aborts and restarts
// the burst with freshly latched tone/num (no done for the aborted burst).
module buzzer_seq
   import buzzer_pkg::*;
#(
   parameter int unsigned BEEP_CYCLES = 25_000_000,
   parameter int unsigned GAP_CYCLES  = 12_500_000,
   parameter int unsigned HP_W        = 20,
   parameter bit          TEST_SIZE   = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [1:0] tone,
   input  logic [2:0] num,
   output logic       buzz,
   output logic       busy,
   output logic       done
);

   localparam int unsigned MAX_CYC = (BEEP_CYCLES > GAP_CYCLES) ? BEEP_CYCLES : GAP_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   state_t           state;
   logic [CNT_W-1:0] dur_cnt;
   logic [2:0]       beeps_left;
   logic [1:0]       tone_q;

   logic            beep_end;
   logic            gap_end;
   logic            last_end;
   logic            retrig;
   logic            div_en;
   logic            div_clr;
   logic [HP_W-1:0] hp;

   assign beep_end = (state == BEEP) && (dur_cnt == CNT_W'(BEEP_CYCLES - 1));
   assign gap_end  = (state == GAP)  && (dur_cnt == CNT_W'(GAP_CYCLES - 1));
   assign last_end = beep_end && (beeps_left == 3'd0);

   // The edge that completes the final beep always finishes normally.
`ifdef BUZZER_RETRIGGER_EN
   assign retrig = start && (state != IDLE) && !last_end;
`else
   assign retrig = 1'b0;
`endif

   // Divider control follows the next state: restart on every BEEP entry,
   // keep running while BEEP continues, silence otherwise.
   assign div_clr = ((state == IDLE) && start) || gap_end || retrig;
   assign div_en  = div_clr || ((state == BEEP) && !beep_end);
   assign hp      = HP_W'(half_period(tone_q, TEST_SIZE));

   tone_div #(.HP_W(HP_W)) u_tone_div (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (div_en),
      .clr         (div_clr),
      .half_period (hp),
      .wave        (buzz)
   );

   // Sequencer FSM with duration and beep counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         dur_cnt    <= '0;
         beeps_left <= '0;
         tone_q     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (retrig) begin
            tone_q     <= tone;
            beeps_left <= num;
            dur_cnt    <= '0;
            state      <= BEEP;
            busy       <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     tone_q     <= tone;
                     beeps_left <= num;
                     dur_cnt    <= '0;
                     state      <= BEEP;
                     busy       <= 1'b1;
                  end
               end
               BEEP: begin
                  if (beep_end) begin
                     dur_cnt <= '0;
                     if (beeps_left != 3'd0) begin
                        beeps_left <= beeps_left - 3'd1;
                        state      <= GAP;
                     end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end else begin
                     dur_cnt <= dur_cnt + CNT_W'(1);
                  end
               end
               GAP: begin
                  if (gap_end) begin
                     dur_cnt <= '0;
                     state   <= BEEP;
                  end else begin
                     dur_cnt <= dur_cnt + CNT_W'(1);
                  end
               end
               default: begin
                  state   <= IDLE;
                  dur_cnt <= '0;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
